ex_mem_pipe: RTL
================

# ex_mem_pipe

Parametrised EX→MEM pipeline stage register with valid/ready handshake, stall back-pressure, flush and a saturating stall counter. It sits between the execute stage and the memory stage and carries the write-enables, ALU result, destination register and write-back source. It replaces the plain always-load EX/MEM register wherever the MEM side can stall, for example on a multi-cycle data memory.

## Interface
- DATA_W, 32, width of the ALU result payload
- ADDR_W, 5, width of the destination register address
- CNT_W, 16, width of the stall counter
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-low
- ex_valid  input  1  EX offers an entry
- ex_ready  output  1  stage can accept this cycle
- ex_reg_wr  input  1  register-file write enable
- ex_mem_wr  input  1  data-memory write enable
- ex_alu_result  input  DATA_W  ALU result or address
- ex_waddr  input  ADDR_W  destination register
- ex_reg_wb_src  input  2  write-back source select
- flush  input  1  kill all held entries; block this cycle's input
- mem_valid  output  1  entry presented to MEM
- mem_ready  input  1  MEM consumes the entry this cycle
- mem_reg_wr, mem_mem_wr  output  1 each  enables, forced 0 when mem_valid=0
- mem_alu_result  output  DATA_W  held result
- mem_waddr  output  ADDR_W  held destination
- mem_reg_wb_src  output  2  held write-back source
- stall_cnt  output  CNT_W  saturating count of stalled cycles

## Operation
- Transfer in: ex_valid && ex_ready && !flush. Transfer out: mem_valid && mem_ready.
- Payload is captured only on a transfer in. It is held unchanged while mem_valid && !mem_ready.
- mem_reg_wr = held reg_wr & mem_valid. mem_mem_wr = held mem_wr & mem_valid. A bubble never writes.
- flush: every entry is invalidated at the next edge. An entry offered in the same cycle is discarded. Flush has priority over both transfers.
- stall_cnt increments each cycle with mem_valid && !mem_ready and saturates at 2^CNT_W−1. It is cleared only by reset. It does not count during a flush cycle.
- Reset (rst=0 at an edge), outputs:
  - mem_valid=0, mem_reg_wr=0, mem_mem_wr=0
  - mem_alu_result=0, mem_waddr=0
  - mem_reg_wb_src=`wb_src_alu_result`
  - stall_cnt=0
  - ex_ready=1 from the first cycle after reset
- Reset applied mid-stall drops held entries without a transfer out.

## Timing
- Latency: 1 cycle from transfer in to mem_valid=1.
- Throughput: 1 entry per cycle while mem_ready=1.
- Simultaneous transfer in and out on a full stage: the new entry replaces the old one, and mem_valid stays 1.
- Base mode (macro undefined):
  - Single entry.
  - ex_ready = !mem_valid || mem_ready. This is a combinational path from mem_ready.
- Skid mode (macro defined):
  - Two entries, main and skid.
  - ex_ready is registered and equals "skid empty".
  - If main is valid and stalled, a transfer in goes to skid.
  - On a transfer out, skid moves to main, or the input moves to main if skid is empty.
  - Order is strictly FIFO.
  - ex_ready falls the cycle after skid fills and rises the cycle after skid drains.
  - Flush clears both entries, and ex_ready=1 the next cycle.

## Configuration
- EX_MEM_SKID_EN:
  - Defined: 2-entry skid mode. No combinational mem_ready→ex_ready path.
  - Undefined: single-register base mode.
- The port list is identical in both modes.

## Test plan
- Reset: hold rst=0 for 3 cycles with ex_valid=1 → mem_valid=0, all payload 0, mem_reg_wb_src=`wb_src_alu_result`, stall_cnt=0.
- Streaming: mem_ready=1, send alu_result 0x10, 0x20, 0x30 on consecutive cycles → each appears exactly 1 cycle later, in order, with no bubbles.
- Stall:
  - Entry 0xAA with mem_ready=0 for 4 cycles → 0xAA held, stall_cnt=4.
  - Base mode: ex_ready=0 during the stall.
  - Skid mode: entry 0xBB is accepted into skid, then ex_ready=0. After release, 0xAA is delivered, then 0xBB.
- Flush: stalled entry with mem_mem_wr=1, assert flush together with a new ex_valid → next cycle mem_valid=0 and mem_mem_wr=0, and the new entry never appears.
- Saturation: CNT_W=4, stall for 20 cycles → stall_cnt stops at 15.
- Bubble gating: ex_valid=0 with ex_reg_wr=1 → mem_reg_wr stays 0.

Source files
------------

// File: rtl/ex_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_pipe
// Brief    : EX->MEM pipeline register with valid/ready handshake, flush and
//            saturating stall counter. Define EX_MEM_SKID_EN for the 2-entry
//            skid variant (registered ex_ready); default is single-entry.
// Revision : 1.0
// ============================================================================
module ex_mem_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_reg_wr,
    input  logic              ex_mem_wr,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [ADDR_W-1:0] ex_waddr,
    input  logic [1:0]        ex_reg_wb_src,
    input  logic              flush,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_reg_wr,
    output logic              mem_mem_wr,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [1:0]        mem_reg_wb_src,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0]       c_wb_src_alu_result = 2'b00;
    localparam int               c_pw        = 4 + ADDR_W + DATA_W;
    localparam int               c_waddr_lsb = DATA_W;
    localparam int               c_wb_lsb    = DATA_W + ADDR_W;
    localparam int               c_memwr_bit = DATA_W + ADDR_W + 2;
    localparam int               c_regwr_bit = DATA_W + ADDR_W + 3;
    localparam logic [c_pw-1:0]  c_rst_payload =
        {2'b00, c_wb_src_alu_result, {(ADDR_W + DATA_W){1'b0}}};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [c_pw-1:0]  w_in_payload;
    logic             w_ex_ready;
    logic             w_xfer_in;
    logic             w_xfer_out;
    logic             w_stall;
    logic             r_main_valid;
    logic [c_pw-1:0]  r_main;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_in_payload = {ex_reg_wr, ex_mem_wr, ex_reg_wb_src, ex_waddr, ex_alu_result};
    assign w_xfer_in    = ex_valid && w_ex_ready && !flush;
    assign w_xfer_out   = r_main_valid && mem_ready;
    assign w_stall      = r_main_valid && !mem_ready;

`ifdef EX_MEM_SKID_EN
    logic             r_skid_valid;
    logic [c_pw-1:0]  r_skid;

    // Ready depends only on state, so mem_ready never reaches ex_ready.
    assign w_ex_ready = !r_skid_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= c_rst_payload;
            r_skid       <= c_rst_payload;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_xfer_out) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_skid_valid <= 1'b0;
            end else if (w_xfer_in) begin
                r_main       <= w_in_payload;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_xfer_in) begin
            // A stalled main entry pushes the newcomer into skid to keep FIFO order.
            if (r_main_valid) begin
                r_skid       <= w_in_payload;
                r_skid_valid <= 1'b1;
            end else begin
                r_main       <= w_in_payload;
                r_main_valid <= 1'b1;
            end
        end
    end
`else
    assign w_ex_ready = !r_main_valid || mem_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_main_valid <= 1'b0;
            r_main       <= c_rst_payload;
        end else begin
            if (flush) begin
                r_main_valid <= 1'b0;
            end else if (w_xfer_in) begin
                r_main_valid <= 1'b1;
            end else if (w_xfer_out) begin
                r_main_valid <= 1'b0;
            end
            if (w_xfer_in) begin
                r_main <= w_in_payload;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (!flush && w_stall && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign ex_ready       = w_ex_ready;
    assign mem_valid      = r_main_valid;
    assign mem_reg_wr     = r_main[c_regwr_bit] & r_main_valid;
    assign mem_mem_wr     = r_main[c_memwr_bit] & r_main_valid;
    assign mem_alu_result = r_main[DATA_W-1:0];
    assign mem_waddr      = r_main[c_waddr_lsb +: ADDR_W];
    assign mem_reg_wb_src = r_main[c_wb_lsb +: 2];
    assign stall_cnt      = r_stall_cnt;

endmodule
`default_nettype wire
